triangle_list: RTL and testbench

Buffers the object triangle list produced by the upstream list loader and replays it to the downstream transform/raster pipeline once per frame. Captures one triangle per cycle on the loader's write strobe into a DEPTH-entry store. On each frame request, streams the stored triangles in write order over a valid/ready handshake and signals frame completion. Sits between the object loader and the vertex-transform stage.

---
 rtl/render_pkg.sv | 15 +
 rtl/triangle_list_if.sv | 27 ++
 rtl/tri_list_mem.sv | 19 +
 rtl/triangle_list.sv | 136 +++++++++++++
 tb/tb_triangle_list.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/render_pkg.sv
// Shared render types and sizing for the triangle list buffer.
package render_pkg;
   localparam int unsigned WI      = 8;
   localparam int unsigned WF      = 8;
   localparam int unsigned COORD_W = WI + WF;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W   = $clog2(DEPTH);

   typedef logic [COORD_W-1:0] coord_t;
   typedef coord_t  [2:0]      vertex_t;
   typedef vertex_t [2:0]      tri_t;

   typedef enum logic [1:0] {IDLE, STREAM, DONE} tri_list_state_t;
endpackage

// File: rtl/triangle_list_if.sv
// Loader write port, frame control and downstream triangle stream of triangle_list.
interface triangle_list_if;
   import render_pkg::*;

   logic             list_w;
   tri_t             orig_triangle_in;
   logic             clear;
   logic             frame_start;
   logic             tri_valid;
   logic             tri_ready;
   tri_t             tri_out;
   logic             tri_last;
   logic             frame_done;
   logic [CNT_W-1:0] tri_count;
   logic             busy;
   logic             ovf;

   modport master (
      output list_w, orig_triangle_in, clear, frame_start, tri_ready,
      input  tri_valid, tri_out, tri_last, frame_done, tri_count, busy, ovf
   );

   modport slave (
      input  list_w, orig_triangle_in, clear, frame_start, tri_ready,
      output tri_valid, tri_out, tri_last, frame_done, tri_count, busy, ovf
   );
endinterface

// File: rtl/tri_list_mem.sv
// Triangle store: one synchronous write port, one combinational indexed read port.
module tri_list_mem
   import render_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  tri_t             wdata,
   input  logic [PTR_W-1:0] raddr,
   output tri_t             rdata
);
   tri_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/triangle_list.sv
// Captures loader triangles and replays them once per frame over valid/ready.
// Define TRI_LIST_OVF_EN to enable the sticky overflow flag (otherwise ovf reads 0).
module triangle_list
   import render_pkg::*;
(
   input  logic           Clk,
   input  logic           Reset_n,
   triangle_list_if.slave bus
);
   tri_list_state_t  state, state_nxt;
   logic [CNT_W-1:0] count_q, count_d, len_q, len_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_addr;
   logic             valid_q, valid_d, last_q, last_d, done_q, done_d;
   logic             busy_q, busy_d, ovf_q, ovf_d;
   tri_t             out_q, out_d, rd_data;
   logic             full, wr_en, hs;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign wr_en = bus.list_w & ~bus.clear & ~full;
   assign hs    = valid_q & bus.tri_ready;

   tri_list_mem u_mem (
      .clk   (Clk),
      .we    (wr_en),
      .waddr (count_q[PTR_W-1:0]),
      .wdata (bus.orig_triangle_in),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // List fill level and overflow tracking, independent of replay state.
   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (bus.clear)  count_d = '0;
      else if (wr_en) count_d = count_q + CNT_W'(1);
`ifdef TRI_LIST_OVF_EN
      ovf_d = ovf_q;
      if (bus.clear)                 ovf_d = 1'b0;
      else if (bus.list_w && full)   ovf_d = 1'b1;
`endif
   end

   always_comb begin
      state_nxt = state;
      len_d     = len_q;
      rd_ptr_d  = rd_ptr_q;
      rd_addr   = '0;
      out_d     = out_q;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.frame_start && !bus.clear) begin
               len_d    = count_q;
               rd_ptr_d = '0;
               if (count_q != '0) begin
                  state_nxt = STREAM;
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
                  out_d     = rd_data;
                  last_d    = (count_q == CNT_W'(1));
               end else begin
                  state_nxt = DONE;
                  done_d    = 1'b1;
               end
            end
         end
         STREAM: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = last_q;
            rd_addr = rd_ptr_q + PTR_W'(1);
            if (hs) begin
               if (last_q) begin
                  state_nxt = DONE;
                  done_d    = 1'b1;
                  valid_d   = 1'b0;
                  busy_d    = 1'b0;
                  last_d    = 1'b0;
               end else begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                  out_d    = rd_data;
                  last_d   = (CNT_W'(rd_ptr_q) + CNT_W'(2) == len_q);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A flush aborts replay silently, whatever the state.
      if (bus.clear) begin
         state_nxt = IDLE;
         valid_d   = 1'b0;
         last_d    = 1'b0;
         done_d    = 1'b0;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         count_q  <= '0;
         len_q    <= '0;
         rd_ptr_q <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         count_q  <= count_d;
         len_q    <= len_d;
         rd_ptr_q <= rd_ptr_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.tri_valid  = valid_q;
   assign bus.tri_out    = out_q;
   assign bus.tri_last   = last_q;
   assign bus.frame_done = done_q;
   assign bus.tri_count  = count_q;
   assign bus.busy       = busy_q;
   assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_triangle_list.sv
// Randomized bench for triangle_list against a queue-based model of the stored list.
module tb_triangle_list;
   import render_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   tri_t model_q[$];
   bit   model_ovf;

   triangle_list_if bus ();
   triangle_list dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic tri_t rand_tri();
      tri_t t;
      for (int v = 0; v < 3; v++)
         for (int c = 0; c < 3; c++)
            t[v][c] = COORD_W'($urandom);
      return t;
   endfunction

   function automatic logic exp_ovf();
`ifdef TRI_LIST_OVF_EN
      return model_ovf;
`else
      return 1'b0;
`endif
   endfunction

   task automatic load_list(input int n);
      tri_t t;
      for (int i = 0; i < n; i++) begin
         t = rand_tri();
         bus.list_w = 1'b1;
         bus.orig_triangle_in = t;
         if (model_q.size() < DEPTH) model_q.push_back(t);
         else model_ovf = 1'b1;
         @(negedge clk);
      end
      bus.list_w = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      model_q.delete();
      model_ovf = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready alternates 1-0-1-0, 2: random ready
   task automatic run_frame(input int mode, input string name);
      int n, idx, cyc;
      logic r;
      n = model_q.size();
      bus.frame_start = 1'b1;
      bus.tri_ready = 1'b0;
      @(negedge clk);
      bus.frame_start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 200) begin
         checks++;
         if (bus.tri_valid !== 1'b1 || bus.tri_out !== model_q[idx] ||
             bus.tri_last !== (idx == n - 1) || bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idx %0d: valid %b last %b busy %b done %b out %h, required valid 1 last %b busy 1 done 0 out %h",
                     name, idx, bus.tri_valid, bus.tri_last, bus.busy, bus.frame_done, bus.tri_out,
                     (idx == n - 1), model_q[idx]);
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = 1'(($urandom % 2));
         endcase
         bus.tri_ready = r;
         if (r) idx++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (idx != n) begin
         errors++;
         $display("FAIL %s timeout: delivered %0d required %0d", name, idx, n);
      end
      if (mode == 0) begin
         checks++;
         if (cyc != n) begin
            errors++;
            $display("FAIL %s latency: frame took %0d cycles required %0d", name, cyc, n);
         end
      end
      checks++;
      if (bus.frame_done !== 1'b1 || bus.tri_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s end: done %b valid %b busy %b required 1 0 0",
                  name, bus.frame_done, bus.tri_valid, bus.busy);
      end
      checks++;
      if (bus.tri_count !== CNT_W'(model_q.size()) || bus.ovf !== exp_ovf()) begin
         errors++;
         $display("FAIL %s count: tri_count %0d ovf %b required %0d %b",
                  name, bus.tri_count, bus.ovf, model_q.size(), exp_ovf());
      end
      bus.tri_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.tri_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: done %b busy %b valid %b required 0 0 0",
                  name, bus.frame_done, bus.busy, bus.tri_valid);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (bus.tri_valid !== 1'b0 || bus.tri_last !== 1'b0 || bus.frame_done !== 1'b0 ||
          bus.busy !== 1'b0 || bus.ovf !== 1'b0 || bus.tri_count !== '0 || bus.tri_out !== '0) begin
         errors++;
         $display("FAIL %s: valid %b last %b done %b busy %b ovf %b count %0d out %h, required all 0",
                  name, bus.tri_valid, bus.tri_last, bus.frame_done, bus.busy, bus.ovf,
                  bus.tri_count, bus.tri_out);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.list_w = 1'b0;
      bus.orig_triangle_in = '0;
      bus.clear = 1'b0;
      bus.frame_start = 1'b0;
      bus.tri_ready = 1'b0;
      model_q.delete();
      model_ovf = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");
   endtask

   task automatic test_stream();
      load_list(12);
      run_frame(0, "stream12");
   endtask

   task automatic test_stall();
      run_frame(1, "stall_alt");
      run_frame(2, "stall_rand");
   endtask

   task automatic test_overflow();
      do_clear();
      load_list(18);
      checks++;
      if (bus.tri_count !== CNT_W'(DEPTH) || bus.ovf !== exp_ovf()) begin
         errors++;
         $display("FAIL overflow: tri_count %0d ovf %b required %0d %b",
                  bus.tri_count, bus.ovf, DEPTH, exp_ovf());
      end
      run_frame(0, "full_replay");
      bus.list_w = 1'b1;
      bus.orig_triangle_in = rand_tri();
      do_clear();
      bus.list_w = 1'b0;
      checks++;
      if (bus.tri_count !== '0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL clear_wins: tri_count %0d ovf %b required 0 0", bus.tri_count, bus.ovf);
      end
   endtask

   task automatic test_empty();
      run_frame(0, "empty");
   endtask

   task automatic test_clear_mid();
      int hs_n;
      load_list(12);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.tri_ready = 1'b1;
      hs_n = 0;
      while (hs_n < 2) begin
         @(negedge clk);
         hs_n++;
      end
      checks++;
      if (bus.tri_out !== model_q[2] || bus.tri_valid !== 1'b1) begin
         errors++;
         $display("FAIL clear_mid_pre: out %h valid %b required %h 1", bus.tri_out, bus.tri_valid, model_q[2]);
      end
      do_clear();
      bus.tri_ready = 1'b0;
      checks++;
      if (bus.tri_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.tri_count !== '0) begin
         errors++;
         $display("FAIL clear_mid: valid %b busy %b done %b count %0d required 0 0 0 0",
                  bus.tri_valid, bus.busy, bus.frame_done, bus.tri_count);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.frame_done !== 1'b0 || bus.tri_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid_after %0d: done %b valid %b required 0 0", i, bus.frame_done, bus.tri_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      load_list(5);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      model_q.delete();
      model_ovf = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid_release");
      load_list(3);
      run_frame(2, "after_reset");
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_overflow();
      test_empty();
      test_clear_mid();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
